// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types and widths for the MIDI voice allocator
// Contents:
//   NOTE_W, VEL_W    widths of a MIDI note number and a MIDI velocity
//   alloc_state_t    allocator FSM states (IDLE, SEARCH, COMMIT)
//   midi_msg_t       one classified message {is_on, note, vel}
//   classify_msg     folds "Note On with velocity 0" into a release
package midi_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    COMMIT = 2'd2
  } alloc_state_t;

  typedef struct packed {
    logic              is_on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
  } midi_msg_t;

  // Note On with zero velocity is the running-status idiom for Note Off.
  function automatic midi_msg_t classify_msg(input logic              on_trig,
                                             input logic [NOTE_W-1:0] note,
                                             input logic [VEL_W-1:0]  vel);
    midi_msg_t m;
    m.is_on = on_trig && (vel != '0);
    m.note  = note;
    m.vel   = vel;
    return m;
  endfunction

endpackage

// File: rtl/midi_voice_allocator_if.sv
// rtl/midi_voice_allocator_if.sv - decoded note-message bus from midi_receiver
// Signals:
//   msg_valid        one-cycle strobe, message fields are valid
//   note_on_trigger  1 = Note On, 0 = Note Off
//   note_number      MIDI note number
//   velocity         MIDI velocity
// Modports: master drives the bus (receiver), slave consumes it (allocator).
interface midi_voice_allocator_if;

  logic                          msg_valid;
  logic                          note_on_trigger;
  logic [midi_pkg::NOTE_W-1:0]   note_number;
  logic [midi_pkg::VEL_W-1:0]    velocity;

  modport master (output msg_valid, output note_on_trigger,
                  output note_number, output velocity);
  modport slave  (input  msg_valid, input  note_on_trigger,
                  input  note_number, input  velocity);

endinterface

// File: rtl/midi_voice_allocator.sv
// rtl/midi_voice_allocator.sv - assigns note-on messages to synth voice slots
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   msg             note-message bus (slave modport)
//   panic           all-notes-off request, level-sampled, beats everything but reset
//   voice_active    gate per voice
//   voice_note      voice i note in bits [7i+6:7i]
//   voice_velocity  same packing as voice_note
//   voice_trigger   one-cycle pulse when a voice is (re)started
//   steal           one-cycle pulse when an active voice was overwritten
//   busy            high while searching or committing
//   overflow        sticky, a message was dropped (cleared only by reset)
// A message is scanned one voice per cycle, then committed in one cycle, so
// outputs move NUM_VOICES+1 edges after msg_valid is sampled.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  midi_voice_allocator_if.slave        msg,
  input  logic                         panic,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_velocity,
  output logic [NUM_VOICES-1:0]        voice_trigger,
  output logic                         steal,
  output logic                         busy,
  output logic                         overflow
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

  alloc_state_t state, next_state;

  logic [IDX_W-1:0]  idx;
  midi_msg_t         cur;
  midi_msg_t         pend;
  logic              pend_full;
  midi_msg_t         in_msg;
  logic              load_pend;

  logic [NOTE_W-1:0] note_q [NUM_VOICES];
  logic [VEL_W-1:0]  vel_q  [NUM_VOICES];
  logic [AGE_W-1:0]  age_q  [NUM_VOICES];

  // Scan results, valid once the last voice has been examined.
  logic              match_found, free_found, old_found;
  logic [IDX_W-1:0]  match_idx, free_idx, old_idx;
  logic [AGE_W-1:0]  old_age;
  logic [IDX_W-1:0]  tgt;

  assign in_msg    = classify_msg(msg.note_on_trigger, msg.note_number, msg.velocity);
  assign load_pend = (state == IDLE) && pend_full;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[g*NOTE_W +: NOTE_W]   = note_q[g];
    assign voice_velocity[g*VEL_W +: VEL_W] = vel_q[g];
  end

  // Re-use beats free slot, free slot beats stealing the oldest.
  always_comb begin
    tgt = old_idx;
    if (match_found)     tgt = match_idx;
    else if (free_found) tgt = free_idx;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    if (panic) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (pend_full || msg.msg_valid) next_state = SEARCH;
        SEARCH:  if (idx == IDX_LAST)            next_state = COMMIT;
        COMMIT:  next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: message intake, scan bookkeeping and voice updates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx           <= '0;
      cur           <= '0;
      pend          <= '0;
      pend_full     <= 1'b0;
      overflow      <= 1'b0;
      voice_active  <= '0;
      voice_trigger <= '0;
      steal         <= 1'b0;
      match_found   <= 1'b0;
      free_found    <= 1'b0;
      old_found     <= 1'b0;
      match_idx     <= '0;
      free_idx      <= '0;
      old_idx       <= '0;
      old_age       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else if (panic) begin
      // Notes and velocities are kept; only gates, ages and queued work go.
      idx           <= '0;
      pend_full     <= 1'b0;
      voice_active  <= '0;
      voice_trigger <= '0;
      steal         <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else begin
      voice_trigger <= '0;
      steal         <= 1'b0;

      if (load_pend) begin
        cur       <= pend;
        pend_full <= 1'b0;
      end

      // The pending slot frees up in the same cycle it is loaded, so a new
      // message arriving then can take its place.
      if (msg.msg_valid) begin
        if (state == IDLE && !pend_full) begin
          cur <= in_msg;
        end else if (!pend_full || load_pend) begin
          pend      <= in_msg;
          pend_full <= 1'b1;
        end else begin
          overflow  <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          idx         <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
          old_found   <= 1'b0;
        end
        SEARCH: begin
          if (voice_active[idx] && note_q[idx] == cur.note && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!voice_active[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (voice_active[idx] && (!old_found || age_q[idx] > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= idx;
            old_age   <= age_q[idx];
          end
          idx <= idx + 1'b1;
        end
        COMMIT: begin
          if (cur.is_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == tgt)
                age_q[i] <= '0;
              else if (voice_active[i] && age_q[i] != AGE_MAX)
                age_q[i] <= age_q[i] + 1'b1;
            end
            voice_active[tgt]  <= 1'b1;
            note_q[tgt]        <= cur.note;
            vel_q[tgt]         <= cur.vel;
            voice_trigger[tgt] <= 1'b1;
            steal              <= !match_found && !free_found;
          end else if (match_found) begin
            voice_active[match_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb/tb_midi_voice_allocator.sv - directed-vector bench for midi_voice_allocator
module tb_midi_voice_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        panic;
  logic [3:0]  voice_active;
  logic [27:0] voice_note;
  logic [27:0] voice_velocity;
  logic [3:0]  voice_trigger;
  logic        steal;
  logic        busy;
  logic        overflow;

  int n_vec    = 0;
  int n_miscmp = 0;

  midi_voice_allocator_if bus ();

  midi_voice_allocator #(.NUM_VOICES(4), .AGE_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .msg            (bus),
    .panic          (panic),
    .voice_active   (voice_active),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .voice_trigger  (voice_trigger),
    .steal          (steal),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    wait_edges(1);
    rst_n = 1'b1;
  endtask

  // Present one message for one edge (E0); returns at E0+1ns.
  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
    @(posedge clk); #1;
    bus.msg_valid       = 1'b1;
    bus.note_on_trigger = on;
    bus.note_number     = note;
    bus.velocity        = vel;
    wait_edges(1);
    bus.msg_valid = 1'b0;
  endtask

  // Send and return just after the commit edge (E0+5+1ns), pulses visible.
  task automatic apply(input logic on, input logic [6:0] note, input logic [6:0] vel);
    send(on, note, vel);
    wait_edges(5);
  endtask

  logic [27:0] exp_notes;

  initial begin
    rst_n               = 1'b0;
    panic               = 1'b0;
    bus.msg_valid       = 1'b0;
    bus.note_on_trigger = 1'b0;
    bus.note_number     = '0;
    bus.velocity        = '0;

    // Reset state and single note-on latency
    do_reset();
    check_vec("rst_active",   {28'b0, voice_active}, 32'h0);
    check_vec("rst_note",     {4'b0, voice_note}, 32'h0);
    check_vec("rst_flags",    {28'b0, busy, steal, overflow, |voice_trigger}, 32'h0);
    send(1'b1, 7'h3C, 7'h40);
    check_vec("busy_c0", {31'b0, busy}, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      wait_edges(1);
      check_vec($sformatf("busy_c%0d", k), {31'b0, busy}, 32'h1);
      check_vec($sformatf("notrig_c%0d", k), {28'b0, voice_trigger}, 32'h0);
    end
    wait_edges(1);
    check_vec("first_active", {28'b0, voice_active}, 32'h1);
    check_vec("first_trig",   {28'b0, voice_trigger}, 32'h1);
    check_vec("first_note",   {25'b0, voice_note[6:0]}, 32'h3C);
    check_vec("first_vel",    {25'b0, voice_velocity[6:0]}, 32'h40);
    check_vec("first_busy",   {31'b0, busy}, 32'h0);
    wait_edges(1);
    check_vec("first_trig_end", {28'b0, voice_trigger}, 32'h0);

    // Fill all voices, then steal the oldest
    do_reset();
    apply(1'b1, 7'd60, 7'h50);
    apply(1'b1, 7'd62, 7'h50);
    apply(1'b1, 7'd64, 7'h50);
    apply(1'b1, 7'd65, 7'h50);
    check_vec("fill_active", {28'b0, voice_active}, 32'hF);
    check_vec("fill_trig",   {28'b0, voice_trigger}, 32'h8);
    check_vec("fill_steal",  {31'b0, steal}, 32'h0);
    apply(1'b1, 7'd67, 7'h50);
    check_vec("steal_pulse", {31'b0, steal}, 32'h1);
    check_vec("steal_trig",  {28'b0, voice_trigger}, 32'h1);
    check_vec("steal_note",  {25'b0, voice_note[6:0]}, 32'd67);
    wait_edges(1);
    check_vec("steal_end",   {31'b0, steal}, 32'h0);

    // Releases: explicit off, on with zero velocity, off of an absent note
    apply(1'b0, 7'd62, 7'h40);
    check_vec("off62_active", {28'b0, voice_active}, 32'hD);
    check_vec("off62_trig",   {28'b0, voice_trigger}, 32'h0);
    check_vec("off62_note",   {25'b0, voice_note[13:7]}, 32'd62);
    check_vec("off62_vel",    {25'b0, voice_velocity[13:7]}, 32'h50);
    apply(1'b1, 7'd64, 7'h00);
    check_vec("vel0_active",  {28'b0, voice_active}, 32'h9);
    apply(1'b0, 7'd70, 7'h40);
    exp_notes = {7'd65, 7'd64, 7'd62, 7'd67};
    check_vec("off70_active", {28'b0, voice_active}, 32'h9);
    check_vec("off70_notes",  {4'b0, voice_note}, {4'b0, exp_notes});

    // Re-strike of a held note updates velocity in place
    do_reset();
    apply(1'b1, 7'd60, 7'h40);
    apply(1'b1, 7'd60, 7'h7F);
    check_vec("retrig_vel",    {25'b0, voice_velocity[6:0]}, 32'h7F);
    check_vec("retrig_trig",   {28'b0, voice_trigger}, 32'h1);
    check_vec("retrig_active", {28'b0, voice_active}, 32'h1);
    check_vec("retrig_steal",  {31'b0, steal}, 32'h0);

    // Three back-to-back messages: one latched, one pending, one dropped
    do_reset();
    @(posedge clk); #1;
    bus.msg_valid = 1'b1; bus.note_on_trigger = 1'b1; bus.velocity = 7'h30;
    bus.note_number = 7'd60;
    wait_edges(1);
    bus.note_number = 7'd61;
    wait_edges(1);
    bus.note_number = 7'd62;
    wait_edges(1);
    bus.msg_valid = 1'b0;
    check_vec("ovf_set", {31'b0, overflow}, 32'h1);
    wait_edges(3);
    check_vec("b2b_a_active", {28'b0, voice_active}, 32'h1);
    check_vec("b2b_a_note",   {25'b0, voice_note[6:0]}, 32'd60);
    wait_edges(6);
    check_vec("b2b_b_active", {28'b0, voice_active}, 32'h3);
    check_vec("b2b_b_trig",   {28'b0, voice_trigger}, 32'h2);
    check_vec("b2b_b_note",   {25'b0, voice_note[13:7]}, 32'd61);
    wait_edges(10);
    check_vec("b2b_drop",     {28'b0, voice_active}, 32'h3);
    check_vec("ovf_sticky",   {31'b0, overflow}, 32'h1);

    // Panic while searching with a pending message queued
    @(posedge clk); #1;
    bus.msg_valid = 1'b1; bus.note_number = 7'd70;
    wait_edges(1);
    bus.note_number = 7'd71;
    wait_edges(1);
    bus.msg_valid = 1'b0;
    wait_edges(1);
    panic = 1'b1;
    wait_edges(1);
    panic = 1'b0;
    check_vec("panic_active", {28'b0, voice_active}, 32'h0);
    check_vec("panic_busy",   {31'b0, busy}, 32'h0);
    check_vec("panic_trig",   {28'b0, voice_trigger}, 32'h0);
    check_vec("panic_ovf",    {31'b0, overflow}, 32'h1);
    wait_edges(15);
    check_vec("panic_nopend", {28'b0, voice_active}, 32'h0);
    check_vec("panic_idle",   {31'b0, busy}, 32'h0);
    do_reset();
    check_vec("rst_ovf_clr",  {31'b0, overflow}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Sits directly downstream of midi_receiver and consumes its decoded note messages (note_on_trigger, note_number, velocity, plus the midi_receiver msg_valid strobe).
- Assigns each note-on to one of NUM_VOICES synth voice slots (reuse same note > free voice > steal oldest) and releases slots on note-off.
- Presents per-voice note/velocity/gate plus a one-cycle retrigger pulse to the envelope/oscillator stage.

Parameters:
- NUM_VOICES, 4, number of voice slots (2..16).
- AGE_W, 8, width of the per-voice saturating age counter used for stealing.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  synchronous active-low reset
- msg_valid  input  1  one-cycle strobe from midi_receiver when the velocity byte is committed
- note_on_trigger  input  1  1 = Note On message, 0 = Note Off
- note_number  input  7  MIDI note
- velocity  input  7  MIDI velocity
- panic  input  1  all-notes-off request, level-sampled
- voice_active  output  NUM_VOICES  gate per voice
- voice_note  output  7*NUM_VOICES  voice i in bits [7i+6:7i]
- voice_velocity  output  7*NUM_VOICES  same packing as voice_note
- voice_trigger  output  NUM_VOICES  one-cycle pulse when a voice is (re)started
- steal  output  1  one-cycle pulse when an active voice was stolen
- busy  output  1  high in SEARCH/COMMIT
- overflow  output  1  sticky; a message was dropped

Behaviour:
- Reset (sync, rst_n low at a clk edge):
  - All outputs 0; ages 0; pending buffer empty; state IDLE.
  - Reset mid-SEARCH aborts with no voice update.
- Message classification:
  - Note On with velocity != 0 is ON.
  - note_on_trigger = 0, or velocity = 0, is OFF.
- FSM states: IDLE, SEARCH, COMMIT.
- IDLE:
  - If pending is full, load it and go to SEARCH.
  - Else if msg_valid, latch the inputs and go to SEARCH with idx = 0.
- SEARCH:
  - Examines voice idx on each cycle, for NUM_VOICES cycles.
  - Records: first active voice with matching note, lowest-index free voice, and oldest active voice (max age, tie -> lowest index).
- COMMIT (1 cycle), then IDLE:
  - ON, with a matching active voice: update its velocity, pulse voice_trigger, reset its age to 0.
  - ON, else with a free voice: set active, note, velocity; pulse trigger; age 0.
  - ON, else: overwrite the oldest voice, pulse trigger and steal.
  - ON, in all three cases: every other active voice's age += 1, saturating at 2^AGE_W-1.
  - OFF with a matching active voice: clear voice_active; note and velocity are retained; no trigger pulse.
  - OFF with no match: no change.
- Latency:
  - msg_valid sampled at edge E0; voice outputs and pulses change at edge E0+NUM_VOICES+1.
  - That is 5 cycles for the default NUM_VOICES = 4.
  - Pulses are high for exactly 1 cycle.
- Buffering:
  - msg_valid while busy, or in the IDLE cycle that loads pending, is stored into the 1-entry pending buffer.
  - msg_valid while pending is already full: the new message is dropped and overflow is set.
  - overflow clears only on reset.
- panic has priority over everything except reset:
  - Next edge: voice_active = 0, ages 0, pending cleared, state IDLE; no pulses.
  - A msg_valid in the same cycle as panic is discarded without setting overflow.
- Back-to-back behaviour:
  - Voices may contain duplicate notes only if NUM_VOICES changes mid-run; that cannot happen.
  - Therefore at most one voice matches a given note.

Decomposition:
- midi_pkg holds:
  - NOTE_W = 7, VEL_W = 7;
  - alloc_state_t enum (IDLE, SEARCH, COMMIT);
  - midi_msg_t struct {is_on, note, vel} used for the latch and pending registers.
- No sub-module: voice state is a register array in this module; search is a sequential scan.

Test Plan:
- Reset, then msg (on, 0x3C, 0x40):
  - 5 cycles later voice_active = 0001, voice 0 holds note 0x3C, vel 0x40.
  - voice_trigger = 0001 for 1 cycle; busy high for 5 cycles.
- ON 60, 62, 64, 65 then ON 67:
  - Voices 0-3 are filled in order.
  - Note 67 replaces voice 0 (oldest), steal pulses, voice_trigger = 0001.
- OFF 62 (note_on_trigger = 0):
  - Voice 1 goes inactive; others unchanged; voice 1 note/vel retained.
  - ON 64 with vel 0 releases voice 2.
  - OFF 70 changes nothing.
- ON 60 vel 0x40, then ON 60 vel 0x7F:
  - Same voice 0 now has vel 0x7F with a trigger pulse.
  - voice_active remains 0001; steal stays 0.
- msg_valid on 3 consecutive cycles (notes 60, 61, 62):
  - 60 and 61 are allocated in order, to voices 0 and 1.
  - 62 is dropped; overflow = 1 and stays 1.
- Pending full, then panic asserted mid-SEARCH:
  - Next cycle voice_active = 0, busy = 0; the pending message is never applied.
  - Then rst_n low for 1 edge clears overflow.
